// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing controller.
//
// Contents:
//   - Default 1024x768 timing constants.
//   - Helpers that derive the line and frame totals.
//   - Display-mode encoding.
//   - Config state encoding.
// There are no ports; this file only holds definitions.

package vga_timing_pkg;

    localparam logic [11:0] DEF_HORI_ACTIVE = 12'd1024;
    localparam logic [11:0] DEF_HORI_FP     = 12'd24;
    localparam logic [11:0] DEF_HORI_SYNCP  = 12'd136;
    localparam logic [11:0] DEF_HORI_BP     = 12'd160;
    localparam logic [11:0] DEF_VERT_ACTIVE = 12'd768;
    localparam logic [11:0] DEF_VERT_FP     = 12'd3;
    localparam logic [11:0] DEF_VERT_SYNCP  = 12'd6;
    localparam logic [11:0] DEF_VERT_BP     = 12'd29;

    // Total length of one axis: active + front porch + sync + back porch.
    // All of the arithmetic is 12-bit.
    function automatic logic [11:0] axis_total(input logic [11:0] active,
                                               input logic [11:0] fp,
                                               input logic [11:0] syncp,
                                               input logic [11:0] bp);
        return active + fp + syncp + bp;
    endfunction

    // Pixels per line.
    function automatic logic [11:0] h_total(input logic [11:0] active,
                                            input logic [11:0] fp,
                                            input logic [11:0] syncp,
                                            input logic [11:0] bp);
        return axis_total(active, fp, syncp, bp);
    endfunction

    // Lines per frame.
    function automatic logic [11:0] v_total(input logic [11:0] active,
                                            input logic [11:0] fp,
                                            input logic [11:0] syncp,
                                            input logic [11:0] bp);
        return axis_total(active, fp, syncp, bp);
    endfunction

    // Display modes. Codes 4 to 7 are reserved; they are still stored and
    // applied unchanged.
    typedef enum logic [2:0] {
        MODE_SOLID = 3'd0,
        MODE_BARS  = 3'd1,
        MODE_GRID  = 3'd2,
        MODE_BOX   = 3'd3
    } disp_mode_e;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/vga_sync_axis.sv
// One timing axis: a wrapping counter plus decode of its active and sync windows.
// The same module is used for the horizontal axis and the vertical axis.
//
// Ports:
//   clk         pixel clock
//   rst         synchronous reset, active-high
//   clr         forces the counter to 0 (used while timing is disabled)
//   inc         advance the counter this cycle
//   cnt         current counter value, 0 .. total-1
//   in_active   cnt lies in the active region
//   sync_level  POL while cnt is inside the sync window, otherwise ~POL

import vga_timing_pkg::*;

module vga_sync_axis #(
    parameter logic [11:0] ACTIVE = DEF_HORI_ACTIVE,
    parameter logic [11:0] FP     = DEF_HORI_FP,
    parameter logic [11:0] SYNCP  = DEF_HORI_SYNCP,
    parameter logic [11:0] BP     = DEF_HORI_BP,
    parameter logic        POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] cnt,
    output logic        in_active,
    output logic        sync_level
);

    localparam logic [11:0] TOTAL      = axis_total(ACTIVE, FP, SYNCP, BP);
    localparam logic [11:0] SYNC_START = ACTIVE + FP;
    localparam logic [11:0] SYNC_END   = ACTIVE + FP + SYNCP;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == TOTAL - 12'd1) ? 12'd0 : cnt + 12'd1;
        end
    end

    assign in_active  = (cnt < ACTIVE);
    // SYNC_END is exclusive, so the window is SYNC_START .. SYNC_END-1.
    assign sync_level = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Timing controller for the VGA pixel pipeline.
// It generates the syncs, the active-video flag, the pixel coordinates and
// the start pulses. It also applies display-mode changes only at frame
// boundaries.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   timing_en    1 = run timing, 0 = hold the counters and outputs idle
//   cfg_wr       single-cycle write strobe for cfg_mode
//   cfg_mode     requested display mode
//   hs, vs       horizontal / vertical sync
//   video_active pixel lies in the active region
//   x_pos, y_pos counter values (also valid during blanking)
//   frame_start  one-cycle pulse at pixel (0,0)
//   line_start   one-cycle pulse at x_pos == 0
//   disp_mode    display mode currently applied
//   cfg_pending  a write is waiting for the next frame boundary
//
// Config FSM:
//   state       | meaning
//   CFG_IDLE    | no write waiting; disp_mode is up to date
//   CFG_PENDING | pend_mode holds a write; it is applied at the next frame_start

import vga_timing_pkg::*;

module vga_timing_ctrl #(
    parameter logic [11:0] HORI_ACTIVE = DEF_HORI_ACTIVE,
    parameter logic [11:0] HORI_FP     = DEF_HORI_FP,
    parameter logic [11:0] HORI_SYNCP  = DEF_HORI_SYNCP,
    parameter logic [11:0] HORI_BP     = DEF_HORI_BP,
    parameter logic [11:0] VERT_ACTIVE = DEF_VERT_ACTIVE,
    parameter logic [11:0] VERT_FP     = DEF_VERT_FP,
    parameter logic [11:0] VERT_SYNCP  = DEF_VERT_SYNCP,
    parameter logic [11:0] VERT_BP     = DEF_VERT_BP,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_en,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_mode,
    output logic        hs,
    output logic        vs,
    output logic        video_active,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        frame_start,
    output logic        line_start,
    output logic [2:0]  disp_mode,
    output logic        cfg_pending
);

    localparam logic [11:0] H_TOTAL = h_total(HORI_ACTIVE, HORI_FP, HORI_SYNCP, HORI_BP);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_act;
    logic        v_act;
    logic        h_sync;
    logic        v_sync;
    logic        h_last;
    logic        origin;
    logic        apply;

    cfg_state_e  state;
    logic [2:0]  pend_mode;

    assign h_last = (h_cnt == H_TOTAL - 12'd1);
    assign origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    // The edge that registers frame_start is also the point where a
    // pending mode is applied, so disp_mode changes in the frame_start cycle.
    assign apply  = timing_en && origin;

    vga_sync_axis #(
        .ACTIVE (HORI_ACTIVE),
        .FP     (HORI_FP),
        .SYNCP  (HORI_SYNCP),
        .BP     (HORI_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .clr        (~timing_en),
        .inc        (1'b1),
        .cnt        (h_cnt),
        .in_active  (h_act),
        .sync_level (h_sync)
    );

    // The vertical counter advances only on the cycle the horizontal counter
    // wraps, so vs can change only on an h_cnt == 0 sample.
    vga_sync_axis #(
        .ACTIVE (VERT_ACTIVE),
        .FP     (VERT_FP),
        .SYNCP  (VERT_SYNCP),
        .BP     (VERT_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .clr        (~timing_en),
        .inc        (h_last),
        .cnt        (v_cnt),
        .in_active  (v_act),
        .sync_level (v_sync)
    );

    // Output registers. Every field is taken from the same (h_cnt, v_cnt)
    // sample, so all outputs lag the counters by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst || !timing_en) begin
            hs           <= ~HS_POL;
            vs           <= ~VS_POL;
            video_active <= 1'b0;
            x_pos        <= '0;
            y_pos        <= '0;
            frame_start  <= 1'b0;
            line_start   <= 1'b0;
        end else begin
            hs           <= h_sync;
            vs           <= v_sync;
            video_active <= h_act && v_act;
            x_pos        <= h_cnt;
            y_pos        <= v_cnt;
            frame_start  <= origin;
            line_start   <= (h_cnt == 12'd0);
        end
    end

    // Config FSM. It keeps its state while timing is disabled, so a write
    // made then is applied at the first frame after enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CFG_IDLE;
            pend_mode   <= '0;
            disp_mode   <= MODE_SOLID;
            cfg_pending <= 1'b0;
        end else if (apply) begin
            // A write that lands on the boundary bypasses the pending stage.
            if (cfg_wr) begin
                pend_mode <= cfg_mode;
                disp_mode <= cfg_mode;
            end else if (state == CFG_PENDING) begin
                disp_mode <= pend_mode;
            end
            state       <= CFG_IDLE;
            cfg_pending <= 1'b0;
        end else if (cfg_wr) begin
            pend_mode   <= cfg_mode;
            state       <= CFG_PENDING;
            cfg_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. It uses reduced timing so that whole
// frames fit in a short run:
//   horizontal 8/2/3/3  -> 16 pixels per line, hs window x = 10..12
//   vertical   6/1/2/1  -> 10 lines per frame, vs window y = 7..8
// u0 uses active-low syncs. u1 uses active-high syncs and shares u0's inputs.

module tb_vga_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_en;
    logic        cfg_wr;
    logic [2:0]  cfg_mode;

    logic        hs0, vs0, va0, fs0, ls0, pend0;
    logic [11:0] x0, y0;
    logic [2:0]  disp0;
    logic        hs1, vs1, va1, fs1, ls1, pend1;
    logic [11:0] x1, y1;
    logic [2:0]  disp1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .HORI_ACTIVE(12'd8), .HORI_FP(12'd2), .HORI_SYNCP(12'd3), .HORI_BP(12'd3),
        .VERT_ACTIVE(12'd6), .VERT_FP(12'd1), .VERT_SYNCP(12'd2), .VERT_BP(12'd1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u0 (
        .clk(clk), .rst(rst), .timing_en(timing_en), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
        .hs(hs0), .vs(vs0), .video_active(va0), .x_pos(x0), .y_pos(y0),
        .frame_start(fs0), .line_start(ls0), .disp_mode(disp0), .cfg_pending(pend0)
    );

    vga_timing_ctrl #(
        .HORI_ACTIVE(12'd8), .HORI_FP(12'd2), .HORI_SYNCP(12'd3), .HORI_BP(12'd3),
        .VERT_ACTIVE(12'd6), .VERT_FP(12'd1), .VERT_SYNCP(12'd2), .VERT_BP(12'd1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u1 (
        .clk(clk), .rst(rst), .timing_en(timing_en), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
        .hs(hs1), .vs(vs1), .video_active(va1), .x_pos(x1), .y_pos(y1),
        .frame_start(fs1), .line_start(ls1), .disp_mode(disp1), .cfg_pending(pend1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge, so inputs change and outputs are
    // sampled away from the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_pos(input int wx, input int wy, input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (x0 == 12'(wx) && y0 == 12'(wy)) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        chk(tag, found, 1);
    endtask

    initial begin
        int pos_err, va_cnt, va_blank, hs_lo, first_hs_x, vs_lo, first_vs_y, first_vs_x;
        int ls_cnt, ls_last, ls_per_err, fs_cnt, fs_first, fs_second, hs1_hi, vs1_hi;
        int early, idle_err;
        logic found;

        rst = 1'b1; timing_en = 1'b0; cfg_wr = 1'b0; cfg_mode = 3'd0;
        @(negedge clk);
        step(2);

        // Reset state.
        chk("rst_hs",   hs0, 1);
        chk("rst_vs",   vs0, 1);
        chk("rst_hs_p1", hs1, 0);
        chk("rst_va",   va0, 0);
        chk("rst_x",    x0, 0);
        chk("rst_y",    y0, 0);
        chk("rst_fs",   fs0, 0);
        chk("rst_ls",   ls0, 0);
        chk("rst_disp", disp0, 0);
        chk("rst_pend", pend0, 0);

        // First enabled edge samples (0,0).
        rst = 1'b0; timing_en = 1'b1;
        step(1);
        chk("en_fs", fs0, 1);
        chk("en_ls", ls0, 1);
        chk("en_va", va0, 1);
        chk("en_x",  x0, 0);
        chk("en_y",  y0, 0);
        chk("en_hs", hs0, 1);
        chk("en_vs", vs0, 1);

        // Two full frames (2 x 160 cycles), starting at the (0,0) sample.
        pos_err = 0; va_cnt = 0; va_blank = 0; hs_lo = 0; first_hs_x = -1;
        vs_lo = 0; first_vs_y = -1; first_vs_x = -1; ls_cnt = 0; ls_last = -1;
        ls_per_err = 0; fs_cnt = 0; fs_first = -1; fs_second = -1; hs1_hi = 0; vs1_hi = 0;
        for (int i = 0; i < 320; i++) begin
            if (x0 != 12'(i % 16) || y0 != 12'((i / 16) % 10)) pos_err++;
            if (va0) begin
                va_cnt++;
                if (y0 >= 12'd6 || x0 >= 12'd8) va_blank++;
            end
            if (!hs0) begin
                hs_lo++;
                if (first_hs_x < 0) first_hs_x = int'(x0);
            end
            if (!vs0) begin
                vs_lo++;
                if (first_vs_y < 0) begin
                    first_vs_y = int'(y0);
                    first_vs_x = int'(x0);
                end
            end
            if (ls0) begin
                ls_cnt++;
                if (ls_last >= 0 && i - ls_last != 16) ls_per_err++;
                ls_last = i;
            end
            if (fs0) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (hs1) hs1_hi++;
            if (vs1) vs1_hi++;
            step(1);
        end
        chk("pos_track",    pos_err, 0);
        chk("va_count",     va_cnt, 96);
        chk("va_in_blank",  va_blank, 0);
        chk("hs_low_count", hs_lo, 60);
        chk("hs_first_x",   first_hs_x, 10);
        chk("vs_low_count", vs_lo, 64);
        chk("vs_first_y",   first_vs_y, 7);
        chk("vs_first_x",   first_vs_x, 0);
        chk("ls_count",     ls_cnt, 20);
        chk("ls_period",    ls_per_err, 0);
        chk("fs_count",     fs_cnt, 2);
        chk("fs_period",    fs_second - fs_first, 160);
        chk("hs_p1_high",   hs1_hi, 60);
        chk("vs_p1_high",   vs1_hi, 64);

        // Mid-frame write, then an overwrite before the boundary.
        wait_pos(4, 3, "wait_cfg1");
        cfg_wr = 1'b1; cfg_mode = 3'd2;
        step(1);
        cfg_wr = 1'b0;
        chk("cfg1_pend", pend0, 1);
        chk("cfg1_disp", disp0, 0);
        step(5);
        chk("cfg1_hold", disp0, 0);
        cfg_wr = 1'b1; cfg_mode = 3'd3;
        step(1);
        cfg_wr = 1'b0;
        chk("cfg2_pend", pend0, 1);
        found = 1'b0; early = 0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (fs0) begin
                found = 1'b1;
                break;
            end
            if (disp0 != 3'd0) early++;
        end
        chk("cfg_fs_seen", found, 1);
        chk("cfg_early",   early, 0);
        chk("cfg_apply",   disp0, 3);
        chk("cfg_clear",   pend0, 0);
        chk("cfg_fs_x",    x0, 0);

        // Write that lands on the apply edge is applied directly.
        wait_pos(15, 9, "wait_edge");
        cfg_wr = 1'b1; cfg_mode = 3'd5;
        step(1);
        cfg_wr = 1'b0;
        chk("coin_fs",   fs0, 1);
        chk("coin_disp", disp0, 5);
        chk("coin_pend", pend0, 0);
        step(1);
        chk("coin_pend2", pend0, 0);

        // Disable mid-frame. A write made while disabled waits for the
        // first frame after re-enable.
        wait_pos(5, 3, "wait_dis");
        timing_en = 1'b0;
        step(1);
        idle_err = 0;
        for (int k = 0; k < 10; k++) begin
            if (hs0 !== 1'b1 || vs0 !== 1'b1 || va0 !== 1'b0 || x0 !== 12'd0 || y0 !== 12'd0 ||
                fs0 !== 1'b0 || ls0 !== 1'b0 || hs1 !== 1'b0 || vs1 !== 1'b0) idle_err++;
            if (k == 3) begin
                cfg_wr = 1'b1; cfg_mode = 3'd6;
            end
            if (k == 4) cfg_wr = 1'b0;
            step(1);
        end
        chk("dis_idle", idle_err, 0);
        chk("dis_pend", pend0, 1);
        chk("dis_disp", disp0, 5);
        timing_en = 1'b1;
        step(1);
        chk("reen_fs",   fs0, 1);
        chk("reen_ls",   ls0, 1);
        chk("reen_x",    x0, 0);
        chk("reen_y",    y0, 0);
        chk("reen_va",   va0, 1);
        chk("reen_disp", disp0, 6);
        chk("reen_pend", pend0, 0);
        chk("reen_hs_p1", hs1, 0);

        // rst wins over cfg_wr and timing_en.
        step(3);
        rst = 1'b1; cfg_wr = 1'b1; cfg_mode = 3'd7;
        step(1);
        rst = 1'b0; cfg_wr = 1'b0;
        chk("rstp_fs",   fs0, 0);
        chk("rstp_x",    x0, 0);
        chk("rstp_disp", disp0, 0);
        chk("rstp_pend", pend0, 0);
        step(1);
        chk("rstp_restart_fs", fs0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
